// File: rtl/depuncture_sched_wifi.sv
// Depuncturing scheduler for 802.11 convolutional code rates 1/2, 2/3 and 3/4.
// It re-inserts erasure slots into a punctured bit stream through a one-deep output register.
module depuncture_sched_wifi #(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       rate,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             valid_in,
  input  logic             data_in,
  output logic             in_ready,
  output logic             valid_out,
  output logic             data_out,
  output logic             erase_out,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             rate_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [1:0]       rate_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt_r;
  logic [2:0]       idx_r;

  logic can_load_s;
  logic slot_d_s;
  logic take_in_s;
  logic last_bit_s;

  // 1/2 = DD, 2/3 = DDDE, 3/4 = DDDEED
  function automatic logic slot_is_d(input logic [1:0] r, input logic [2:0] i);
    case (r)
      2'b00:   slot_is_d = 1'b1;
      2'b01:   slot_is_d = (i != 3'd3);
      2'b10:   slot_is_d = (i != 3'd3) && (i != 3'd4);
      default: slot_is_d = 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] next_idx(input logic [1:0] r, input logic [2:0] i);
    logic [2:0] last;
    case (r)
      2'b00:   last = 3'd1;
      2'b01:   last = 3'd3;
      2'b10:   last = 3'd5;
      default: last = 3'd1;
    endcase
    next_idx = (i == last) ? 3'd0 : i + 3'd1;
  endfunction

  // Slot decode and input handshake
  always_comb begin
    can_load_s = !valid_out || out_ready;
    slot_d_s   = slot_is_d(rate_r, idx_r);
    in_ready   = (state_r == RUN) && slot_d_s && can_load_s;
    take_in_s  = valid_in && in_ready;
    last_bit_s = take_in_s && (cnt_r == (len_r - LEN_ONE));
    busy       = (state_r != IDLE);
  end

  // Frame sequencer with output register and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      rate_r    <= 2'b00;
      len_r     <= LEN_ZERO;
      cnt_r     <= LEN_ZERO;
      idx_r     <= 3'd0;
      valid_out <= 1'b0;
      data_out  <= 1'b0;
      erase_out <= 1'b0;
      done      <= 1'b0;
      rate_err  <= 1'b0;
    end else begin
      done     <= 1'b0;
      rate_err <= 1'b0;
      // A transferred beat empties the register unless a new slot loads below
      if (valid_out && out_ready) begin
        valid_out <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            if (rate == 2'b11) begin
              rate_err <= 1'b1;
            end else begin
              rate_r  <= rate;
              len_r   <= frame_len;
              idx_r   <= 3'd0;
              cnt_r   <= LEN_ZERO;
              state_r <= (frame_len == LEN_ZERO) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (take_in_s) begin
            valid_out <= 1'b1;
            data_out  <= data_in;
            erase_out <= 1'b0;
            idx_r     <= next_idx(rate_r, idx_r);
            cnt_r     <= cnt_r + LEN_ONE;
            if (last_bit_s) begin
              state_r <= FLUSH;
            end
          end else if (!slot_d_s && can_load_s) begin
            valid_out <= 1'b1;
            data_out  <= 1'b0;
            erase_out <= 1'b1;
            idx_r     <= next_idx(rate_r, idx_r);
          end
        end
        FLUSH: begin
          // Trailing erasures end at the next data slot (index 0 always is one)
          if (slot_d_s) begin
            state_r <= DRAIN;
          end else if (can_load_s) begin
            valid_out <= 1'b1;
            data_out  <= 1'b0;
            erase_out <= 1'b1;
            idx_r     <= next_idx(rate_r, idx_r);
          end
        end
        DRAIN: begin
          if (can_load_s) begin
            done    <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_depuncture_sched_wifi.sv
// Directed bench for depuncture_sched_wifi: hand-computed beat sequences per code rate,
// stall stability, invalid rate, empty frame and mid-frame reset.
module tb_depuncture_sched_wifi;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  rate;
  logic [11:0] frame_len;
  logic        valid_in;
  logic        data_in;
  logic        in_ready;
  logic        valid_out;
  logic        data_out;
  logic        erase_out;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        rate_err;

  int errors = 0;
  int checks = 0;
  int beats[$];
  int exp_q[$];
  int done_cnt = 0;
  int rerr_cnt = 0;
  int stall_cnt;
  bit last_done;

  depuncture_sched_wifi #(.LEN_W(12)) dut (
    .clk(clk), .reset(reset), .start(start), .rate(rate), .frame_len(frame_len),
    .valid_in(valid_in), .data_in(data_in), .in_ready(in_ready),
    .valid_out(valid_out), .data_out(data_out), .erase_out(erase_out),
    .out_ready(out_ready), .busy(busy), .done(done), .rate_err(rate_err)
  );

  always #5 clk = ~clk;

  // Beat/pulse monitor; beats coded 0/1 for data, 2 for erasure
  always @(negedge clk) begin
    if (valid_out && out_ready) beats.push_back(erase_out ? 2 : int'(data_out));
    if (done) done_cnt++;
    if (rate_err) rerr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_beats(input string tag);
    check({tag, "_count"}, 32'(beats.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), (i < beats.size()) ? 32'(beats[i]) : 32'hFFFF, 32'(exp_q[i]));
  endtask

  // Runs one frame; ends on done, a 200-cycle budget, or once abort_beats beats are seen
  task automatic run_frame(input logic [1:0] r, input int len, input logic [15:0] bits,
                           input bit toggle, input int abort_beats);
    int bi = 0;
    int cyc = 0;
    bit xfer;
    bit hold_pend = 1'b0;
    logic [2:0] prev = 3'b000;
    beats.delete();
    done_cnt  = 0;
    stall_cnt = 0;
    last_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; rate = r; frame_len = len[11:0]; valid_in = 1'b0;
    @(posedge clk); #1;
    // Scrambled controls must not disturb the latched frame
    start = 1'b0; rate = 2'b11; frame_len = 12'hFFF;
    while (!last_done && cyc < 200 && beats.size() < abort_beats) begin
      valid_in  = (bi < len);
      data_in   = (bi < len) ? bits[bi] : 1'b0;
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (hold_pend) check("hold", {29'd0, valid_out, data_out, erase_out}, {29'd0, prev});
      hold_pend = valid_out && !out_ready;
      prev = {valid_out, data_out, erase_out};
      xfer = valid_in && in_ready;
      if (valid_in && !in_ready && busy) stall_cnt++;
      if (done) last_done = 1'b1;
      if (toggle && cyc == 3) start = 1'b1;  // start while busy is ignored
      @(posedge clk); #1;
      start = 1'b0;
      if (xfer) bi++;
      cyc++;
    end
    valid_in  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rate = 2'b00; frame_len = 12'd0;
    valid_in = 1'b0; data_in = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {25'd0, valid_out, data_out, erase_out, in_ready, busy, done, rate_err}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Rate 3/4, 8 bits
    run_frame(2'b10, 8, 16'h00ED, 1'b0, 1000);
    check("r34_done_seen", 32'(last_done), 32'd1);
    repeat (3) @(posedge clk);
    exp_q = '{1, 0, 1, 2, 2, 1, 0, 1, 1, 2, 2, 1};
    check_beats("r34");
    check("r34_done_cnt", 32'(done_cnt), 32'd1);
    check("r34_e_stalls", 32'(stall_cnt), 32'd4);
    check("r34_idle", {31'd0, busy}, 32'd0);

    // Rate 2/3, 3 bits, tail erasure via FLUSH
    run_frame(2'b01, 3, 16'h0003, 1'b0, 1000);
    check("r23_done_seen", 32'(last_done), 32'd1);
    repeat (3) @(posedge clk);
    exp_q = '{1, 1, 0, 2};
    check_beats("r23");
    check("r23_done_cnt", 32'(done_cnt), 32'd1);

    // Rate 1/2, 4 bits, out_ready toggling
    run_frame(2'b00, 4, 16'h0009, 1'b1, 1000);
    check("r12_done_seen", 32'(last_done), 32'd1);
    repeat (3) @(posedge clk);
    exp_q = '{1, 0, 0, 1};
    check_beats("r12");
    check("r12_done_cnt", 32'(done_cnt), 32'd1);

    // Invalid rate
    beats.delete(); rerr_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; rate = 2'b11; frame_len = 12'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("rerr_pulse", {30'd0, rate_err, busy}, 32'b10);
    @(negedge clk);
    check("rerr_clear", {30'd0, rate_err, busy}, 32'b00);
    repeat (2) @(posedge clk);
    check("rerr_cnt", 32'(rerr_cnt), 32'd1);
    check("rerr_beats", 32'(beats.size()), 32'd0);

    // Empty frame at rate 3/4
    beats.delete(); done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; rate = 2'b10; frame_len = 12'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("len0_c1", {30'd0, busy, done}, 32'b10);
    @(negedge clk);
    check("len0_c2", {30'd0, busy, done}, 32'b01);
    @(negedge clk);
    check("len0_c3", {30'd0, busy, done}, 32'b00);
    check("len0_beats", 32'(beats.size()), 32'd0);

    // Reset after 5 beats of a 3/4 frame, then a fresh 1/2 frame
    run_frame(2'b10, 8, 16'h00ED, 1'b0, 5);
    check("abort_beats", 32'(beats.size()), 32'd5);
    reset = 1'b1;
    #1;
    check("abort_outs", {25'd0, valid_out, data_out, erase_out, in_ready, busy, done, rate_err}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_frame(2'b00, 4, 16'h0006, 1'b0, 1000);
    check("after_done_seen", 32'(last_done), 32'd1);
    repeat (3) @(posedge clk);
    exp_q = '{0, 1, 1, 0};
    check_beats("after");
    check("after_done_cnt", 32'(done_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/depuncture_sched_wifi.md
DEPUNCTURE_SCHED_WIFI -- requirements
Module: depuncture_sched_wifi

Interface
REQ-001 SHALL have parameter LEN_W, default 12, width of frame length and input-bit counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle frame start pulse; sampled in IDLE only.
REQ-005 SHALL have port rate  input  2  00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = invalid; latched on accepted start.
REQ-006 SHALL have port frame_len  input  LEN_W  number of punctured input bits in the frame; latched on accepted start.
REQ-007 SHALL have ports valid_in  input  1, data_in  input  1, in_ready  output  1  punctured bit stream; a bit transfers when valid_in & in_ready.
REQ-008 SHALL have ports valid_out  output  1, data_out  output  1, erase_out  output  1, out_ready  input  1  depunctured stream; a beat transfers when valid_out & out_ready.
REQ-009 SHALL have ports busy  output  1, done  output  1, rate_err  output  1  status.

Function
REQ-010 SHALL implement states IDLE, RUN, FLUSH, DRAIN.
REQ-011 IDLE: start with rate != 11 SHALL latch rate and frame_len, clear pattern index and input counter, and go to RUN (or DRAIN if frame_len = 0).
REQ-012 IDLE: start with rate = 11 SHALL pulse rate_err for one cycle and remain in IDLE.
REQ-013 Slot patterns (D = data slot consuming one input bit, E = erasure slot): 1/2 = D D (period 2); 2/3 = D D D E (period 4); 3/4 = D D D E E D (period 6).
REQ-014 The pattern index SHALL advance by one on every loaded output slot and wrap to 0 after the last slot of the period.
REQ-015 The output register SHALL be loadable when valid_out = 0 or out_ready = 1 ("can_load").
REQ-016 in_ready SHALL be 1 only in RUN, at a D slot, with can_load = 1.
REQ-017 At a D slot, an input transfer SHALL load data_out = data_in, erase_out = 0, valid_out = 1 on the next edge (latency 1 cycle).
REQ-018 At an E slot in RUN, with can_load = 1, the register SHALL load data_out = 0, erase_out = 1, valid_out = 1 without consuming input.
REQ-019 valid_out, data_out and erase_out SHALL hold stable while valid_out = 1 and out_ready = 0.
REQ-020 valid_out SHALL clear after a transfer when nothing new is loaded in the same cycle.
REQ-021 When the transfer of input bit number frame_len occurs, the next state SHALL be FLUSH.
REQ-022 FLUSH SHALL emit the erasure slots that immediately follow in the current pattern (0, 1 or 2), then go to DRAIN; no input is accepted.
REQ-023 DRAIN SHALL wait until the output register is empty or its last beat transfers, then pulse done for one cycle and return to IDLE.
REQ-024 busy SHALL be 1 in RUN, FLUSH and DRAIN, and 0 in IDLE.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 Changes to rate and frame_len after the accepted start SHALL NOT affect the frame in progress.
REQ-027 The input counter SHALL be LEN_W bits wide and SHALL never wrap within a frame.

Reset
REQ-028 reset SHALL asynchronously force IDLE, pattern index 0, counter 0, and valid_out, data_out, erase_out, in_ready, busy, done, rate_err all to 0.
REQ-029 reset asserted mid-frame SHALL discard the frame without a done pulse; after release the block SHALL accept a new start.

Verification
REQ-030 Rate 3/4, frame_len = 8, bits 1,0,1,1,0,1,1,1, out_ready = 1 -> outputs 1,0,1,E,E,1,0,1,1,E,E,1 (12 beats), in_ready low on the E cycles, one done pulse.
REQ-031 Rate 2/3, frame_len = 3, bits 1,1,0 -> 1,1,0,E via FLUSH; done pulse; exactly 4 beats.
REQ-032 Rate 1/2, frame_len = 4, out_ready toggling 1,0,1,0 -> 4 data beats in order, no erasures, outputs stable while stalled, no dropped or duplicated bits.
REQ-033 start with rate = 11 -> rate_err pulses for one cycle, busy stays 0, no output.
REQ-034 frame_len = 0 at rate 3/4 -> no beats, done pulses 2 cycles after start.
REQ-035 Reset asserted after 5 beats of a 3/4 frame -> all outputs 0 immediately, no done; a new 1/2 frame then completes normally.
